// File: rtl/ula_issue.sv
// Decodes an RV32I instruction into an ALU code and operand pair and holds it in one issue slot for the ula block.
// Latency: an instruction accepted on a rising edge is on the outputs right after that edge.
// Backpressure: ready_out = ~valid_out | ready_in, so the slot gives full throughput; a stalled slot holds every output bit-stable.
// Ports: clk, reset (async, active-high); valid_in/ready_out upstream handshake; opcode_in, funct3_in, funct7_in,
//        rs1_data_in, rs2_data_in, imm_in, pc_in decode inputs; flush kills the slot and any incoming instruction;
//        valid_out/ready_in downstream handshake; select_ula, data1_out, data2_out, funct3_out, illegal_out registered issue.
module ula_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic [6:0]  opcode_in,
  input  logic [2:0]  funct3_in,
  input  logic [6:0]  funct7_in,
  input  logic [31:0] rs1_data_in,
  input  logic [31:0] rs2_data_in,
  input  logic [31:0] imm_in,
  input  logic [31:0] pc_in,
  input  logic        flush,
  output logic        valid_out,
  input  logic        ready_in,
  output logic [3:0]  select_ula,
  output logic [31:0] data1_out,
  output logic [31:0] data2_out,
  output logic [2:0]  funct3_out,
  output logic        illegal_out
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_NONE = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_OR   = 4'b1001;
  localparam logic [3:0] ALU_AND  = 4'b1010;

  // funct3 codes whose meaning does not depend on funct7 (both OP and OP-IMM).
  function automatic logic [3:0] plain_code(input logic [2:0] f3);
    case (f3)
      3'b001:  plain_code = ALU_SLL;
      3'b010:  plain_code = ALU_SLT;
      3'b011:  plain_code = ALU_SLTU;
      3'b100:  plain_code = ALU_XOR;
      3'b110:  plain_code = ALU_OR;
      3'b111:  plain_code = ALU_AND;
      default: plain_code = ALU_NONE;
    endcase
  endfunction

  logic [3:0]  sel_d;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] data1_d;
  logic [31:0] data2_d;
  logic        ill_d;
  logic        accept;

  always_comb begin
    sel_d = ALU_NONE;
    src1  = 32'd0;
    src2  = 32'd0;
    ill_d = 1'b0;
    case (opcode_in)
      OPC_OP: begin
        src1 = rs1_data_in;
        src2 = rs2_data_in;
        case (funct3_in)
          3'b000: begin
            if (funct7_in == F7_BASE)     sel_d = ALU_ADD;
            else if (funct7_in == F7_ALT) sel_d = ALU_SUB;
            else                          ill_d = 1'b1;
          end
          3'b101: begin
            if (funct7_in == F7_BASE)     sel_d = ALU_SRL;
            else if (funct7_in == F7_ALT) sel_d = ALU_SRA;
            else                          ill_d = 1'b1;
          end
          default: begin
            if (funct7_in == F7_BASE) sel_d = plain_code(funct3_in);
            else                      ill_d = 1'b1;
          end
        endcase
      end
      OPC_OPIMM: begin
        src1 = rs1_data_in;
        src2 = imm_in;
        // Outside the shifts, funct7 is just immediate bits and is ignored.
        case (funct3_in)
          3'b000: sel_d = ALU_ADD;
          3'b001: begin
            if (funct7_in == F7_BASE) sel_d = ALU_SLL;
            else                      ill_d = 1'b1;
          end
          3'b101: begin
            if (funct7_in == F7_BASE)     sel_d = ALU_SRL;
            else if (funct7_in == F7_ALT) sel_d = ALU_SRA;
            else                          ill_d = 1'b1;
          end
          default: sel_d = plain_code(funct3_in);
        endcase
      end
      OPC_LUI: begin
        sel_d = ALU_ADD;
        src2  = imm_in;
      end
      OPC_AUIPC: begin
        sel_d = ALU_ADD;
        src1  = pc_in;
        src2  = imm_in;
      end
      OPC_JAL, OPC_JALR: begin
        // Link address pc + 4.
        sel_d = ALU_ADD;
        src1  = pc_in;
        src2  = 32'd4;
      end
      OPC_LOAD, OPC_STORE: begin
        sel_d = ALU_ADD;
        src1  = rs1_data_in;
        src2  = imm_in;
      end
      OPC_BRANCH: begin
        src1 = rs1_data_in;
        src2 = rs2_data_in;
        case (funct3_in)
          3'b000, 3'b001: sel_d = ALU_SUB;
          3'b100, 3'b101: sel_d = ALU_SLT;
          3'b110, 3'b111: sel_d = ALU_SLTU;
          default:        ill_d = 1'b1;
        endcase
      end
      default: ill_d = 1'b1;
    endcase

    data1_d = src1;
    data2_d = src2;
    if (ill_d) begin
      sel_d   = ALU_NONE;
      data1_d = 32'd0;
      data2_d = 32'd0;
    end else if (sel_d == ALU_SLL || sel_d == ALU_SRL || sel_d == ALU_SRA) begin
      // ula does not mask the SLL shift amount, so clip it here for all shifts.
      data2_d = {27'd0, src2[4:0]};
    end
  end

  assign ready_out = ~valid_out | ready_in;
  assign accept    = valid_in & ready_out & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out   <= 1'b0;
      select_ula  <= ALU_NONE;
      data1_out   <= 32'd0;
      data2_out   <= 32'd0;
      funct3_out  <= 3'd0;
      illegal_out <= 1'b0;
    end else if (flush) begin
      // Data registers keep stale values; valid_out alone marks them dead.
      valid_out <= 1'b0;
    end else if (accept) begin
      valid_out   <= 1'b1;
      select_ula  <= sel_d;
      data1_out   <= data1_d;
      data2_out   <= data2_d;
      funct3_out  <= funct3_in;
      illegal_out <= ill_d;
    end else if (valid_out && ready_in) begin
      valid_out <= 1'b0;
    end
  end

endmodule
